control_unit_fsm: RTL and testbench

Multicycle control unit that sequences the 64-bit datapath `fd`. It decodes `opcode`/`funct3`/`funct7[5]` and steps each instruction through FETCH, DECODE, EXEC, MEM and WB. In each state it drives the datapath strobes (`rf_we`, `d_mem_we`, `pc_load`, muxes, `alu_cmd`) and resolves branches from `alu_flags`. It also counts retired instructions.

---
 rtl/control_unit_pkg.sv | 61 ++++++
 rtl/control_unit_fsm_branch_eval.sv | 29 ++
 rtl/control_unit_fsm.sv | 147 ++++++++++++++
 tb/tb_control_unit_fsm.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared constants, state encoding and instruction decode for the multicycle control unit.
package control_unit_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;

    localparam int FLAG_ZERO   = 0;
    localparam int FLAG_MSB    = 1;
    localparam int FLAG_OVF    = 2;
    localparam int FLAG_UNUSED = 3;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] cmd;
        logic       src;
    } decode_t;

    // br_valid comes from branch_eval so branch funct3 legality lives in one place.
    function automatic decode_t decode(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic f7_5, input logic br_valid);
        decode_t d;
        d = '{legal: 1'b0, cmd: ALU_ADD, src: 1'b0};
        case (opc)
            OPC_OP: begin
                case (f3)
                    3'b000:  begin d.legal = 1'b1; d.cmd = f7_5 ? ALU_SUB : ALU_ADD; end
                    3'b111:  begin d.legal = 1'b1; d.cmd = ALU_AND; end
                    3'b110:  begin d.legal = 1'b1; d.cmd = ALU_OR;  end
                    default: d.legal = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                d.legal = (f3 == 3'b000);
                d.src   = 1'b1;
            end
            OPC_LOAD, OPC_STORE: begin
                d.legal = 1'b1;
                d.src   = 1'b1;
            end
            OPC_BRANCH: begin
                d.legal = br_valid;
                d.cmd   = ALU_SUB;
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/control_unit_fsm_branch_eval.sv
// Combinational branch resolution from funct3 and the ALU flags of a subtract.
module branch_eval
    import control_unit_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [3:0] alu_flags,
    output logic       taken,
    output logic       valid
);

    logic lt;
    logic flag_unused;

    assign lt          = alu_flags[FLAG_MSB] ^ alu_flags[FLAG_OVF];
    assign flag_unused = alu_flags[FLAG_UNUSED];

    always_comb begin
        taken = 1'b0;
        valid = 1'b1;
        case (funct3)
            3'b000:  taken = alu_flags[FLAG_ZERO];
            3'b001:  taken = !alu_flags[FLAG_ZERO];
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit_fsm.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the fd datapath.
// Build option: UC_ILLEGAL_TRAP_EN sends illegal instructions to HALT instead of running them as NOPs.
module control_unit_fsm
    import control_unit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic [3:0]       alu_flags,
    output logic             pc_load,
    output logic             rf_we,
    output logic             d_mem_we,
    output logic [3:0]       alu_cmd,
    output logic             alu_src,
    output logic             pc_src,
    output logic             rf_src,
    output logic             busy,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t     state;
    logic [6:0] opcode_q;
    logic [2:0] funct3_q;
    logic       ill_q;
    logic       pc_load_q;
    logic       rf_we_q;
    logic       d_mem_we_q;
    logic [2:0] be_funct3;
    logic       be_taken;
    logic       be_valid;
    logic       exec_branch;
    decode_t    dec;

    // Live funct3 is decoded in DECODE; afterwards the latched copy drives branch resolution.
    assign be_funct3 = (state == S_DECODE) ? funct3 : funct3_q;

    branch_eval u_branch_eval (
        .funct3    (be_funct3),
        .alu_flags (alu_flags),
        .taken     (be_taken),
        .valid     (be_valid)
    );

    assign dec         = decode(opcode, funct3, funct7_5, be_valid);
    assign exec_branch = (state == S_EXEC) && !ill_q && (opcode_q == OPC_BRANCH);

    // Write strobes are gated by rst_n so a reset cycle can never commit state.
    assign pc_load  = pc_load_q  & rst_n;
    assign rf_we    = rf_we_q    & rst_n;
    assign d_mem_we = d_mem_we_q & rst_n;
    assign pc_src   = exec_branch & be_taken;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            opcode_q   <= '0;
            funct3_q   <= '0;
            ill_q      <= 1'b0;
            pc_load_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            d_mem_we_q <= 1'b0;
            alu_cmd    <= ALU_ADD;
            alu_src    <= 1'b0;
            rf_src     <= 1'b0;
            busy       <= 1'b0;
            illegal    <= 1'b0;
            instret    <= '0;
        end else begin
            if (pc_load_q)
                instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
            pc_load_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            d_mem_we_q <= 1'b0;
            rf_src     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    opcode_q <= opcode;
                    funct3_q <= funct3;
                    ill_q    <= !dec.legal;
                    alu_cmd  <= dec.legal ? dec.cmd : ALU_ADD;
                    alu_src  <= dec.legal & dec.src;
`ifdef UC_ILLEGAL_TRAP_EN
                    if (!dec.legal) begin
                        state   <= S_HALT;
                        busy    <= 1'b0;
                        illegal <= 1'b1;
                    end else begin
                        state     <= S_EXEC;
                        pc_load_q <= (opcode == OPC_BRANCH);
                    end
`else
                    state     <= S_EXEC;
                    pc_load_q <= !dec.legal || (opcode == OPC_BRANCH);
`endif
                end
                S_EXEC: begin
                    if (ill_q || opcode_q == OPC_BRANCH) begin
                        state   <= S_FETCH;
                        alu_cmd <= ALU_ADD;
                        alu_src <= 1'b0;
                    end else if (opcode_q == OPC_LOAD || opcode_q == OPC_STORE) begin
                        state      <= S_MEM;
                        d_mem_we_q <= (opcode_q == OPC_STORE);
                        pc_load_q  <= (opcode_q == OPC_STORE);
                    end else begin
                        state     <= S_WB;
                        rf_we_q   <= 1'b1;
                        pc_load_q <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (opcode_q == OPC_LOAD) begin
                        state     <= S_WB;
                        rf_we_q   <= 1'b1;
                        rf_src    <= 1'b1;
                        pc_load_q <= 1'b1;
                    end else begin
                        state   <= S_FETCH;
                        alu_cmd <= ALU_ADD;
                        alu_src <= 1'b0;
                    end
                end
                S_WB: begin
                    state   <= S_FETCH;
                    alu_cmd <= ALU_ADD;
                    alu_src <= 1'b0;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Directed bench for control_unit_fsm: per-cycle strobe windows checked against hand-derived patterns.
module tb_control_unit_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [3:0]  alu_flags;
    logic        pc_load, rf_we, d_mem_we, alu_src, pc_src, rf_src, busy, illegal;
    logic [3:0]  alu_cmd;
    logic [31:0] instret;

    int errors = 0;
    int checks = 0;
    int exp_instret = 0;

    // Bit k of each window holds the output in cycle k+1 of the instruction (cycle 1 = FETCH).
    logic [7:0] r_rf_we, r_pc_load, r_dmem, r_rf_src, r_pc_src, r_busy, r_ill, r_src;
    logic [3:0] r_cmd [8];

    control_unit_fsm #(.CNT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .alu_flags (alu_flags),
        .pc_load   (pc_load),
        .rf_we     (rf_we),
        .d_mem_we  (d_mem_we),
        .alu_cmd   (alu_cmd),
        .alu_src   (alu_src),
        .pc_src    (pc_src),
        .rf_src    (rf_src),
        .busy      (busy),
        .illegal   (illegal),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [3:0] fl);
        opcode    = o;
        funct3    = f3;
        funct7_5  = f7;
        alu_flags = fl;
    endtask

    task automatic record(input int n);
        r_rf_we = '0; r_pc_load = '0; r_dmem = '0; r_rf_src = '0;
        r_pc_src = '0; r_busy = '0; r_ill = '0; r_src = '0;
        for (int k = 0; k < 8; k++) r_cmd[k] = 4'h0;
        for (int k = 0; k < n; k++) begin
            #1;
            r_rf_we[k]   = rf_we;
            r_pc_load[k] = pc_load;
            r_dmem[k]    = d_mem_we;
            r_rf_src[k]  = rf_src;
            r_pc_src[k]  = pc_src;
            r_busy[k]    = busy;
            r_ill[k]     = illegal;
            r_src[k]     = alu_src;
            r_cmd[k]     = alu_cmd;
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        set_instr(7'h00, 3'h0, 1'b0, 4'h0);
        step();
        step();
        checks++;
        if ({pc_load, rf_we, d_mem_we, alu_src, pc_src, rf_src, busy, illegal} !== 8'h00) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 00000000",
                     {pc_load, rf_we, d_mem_we, alu_src, pc_src, rf_src, busy, illegal});
        end
        checks++;
        if (alu_cmd !== 4'b0000) begin
            errors++;
            $display("FAIL reset_alu_cmd: got %b expected 0000", alu_cmd);
        end
        checks++;
        if (instret !== 32'd0) begin
            errors++;
            $display("FAIL reset_instret: got %0d expected 0", instret);
        end
        start = 1'b0;
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_with_reset_ignored: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_add();
        do_start();
        set_instr(7'b0110011, 3'b000, 1'b0, 4'h0);
        record(4);
        exp_instret++;
        checks++;
        if (r_rf_we !== 8'h08) begin errors++; $display("FAIL add_rf_we: got %b expected 00001000", r_rf_we); end
        checks++;
        if (r_pc_load !== 8'h08) begin errors++; $display("FAIL add_pc_load: got %b expected 00001000", r_pc_load); end
        checks++;
        if (r_dmem !== 8'h00 || r_rf_src !== 8'h00) begin
            errors++; $display("FAIL add_dmem_rfsrc: got %b/%b expected 0/0", r_dmem, r_rf_src);
        end
        checks++;
        if (r_busy !== 8'h0F) begin errors++; $display("FAIL add_busy: got %b expected 00001111", r_busy); end
        checks++;
        if (r_cmd[2] !== 4'b0000 || r_src[2] !== 1'b0) begin
            errors++; $display("FAIL add_exec_cmd: got %b/%b expected 0000/0", r_cmd[2], r_src[2]);
        end
        checks++;
        if (instret !== 32'(exp_instret)) begin
            errors++; $display("FAIL add_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_alu_ops();
        logic [6:0] t_opc [4] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011};
        logic [2:0] t_f3  [4] = '{3'b000, 3'b111, 3'b110, 3'b000};
        logic       t_f7  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] t_cmd [4] = '{4'b0011, 4'b0001, 4'b0010, 4'b0000};
        logic       t_src [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            set_instr(t_opc[i], t_f3[i], t_f7[i], 4'h0);
            record(4);
            exp_instret++;
            checks++;
            if (r_cmd[2] !== t_cmd[i] || r_src[2] !== t_src[i]) begin
                errors++;
                $display("FAIL alu_op%0d_cmd: got %b/%b expected %b/%b", i, r_cmd[2], r_src[2], t_cmd[i], t_src[i]);
            end
            checks++;
            if (r_rf_we !== 8'h08 || r_pc_load !== 8'h08) begin
                errors++;
                $display("FAIL alu_op%0d_wb: got %b/%b expected 00001000/00001000", i, r_rf_we, r_pc_load);
            end
        end
        checks++;
        if (instret !== 32'(exp_instret)) begin
            errors++; $display("FAIL alu_ops_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_load();
        set_instr(7'b0000011, 3'b011, 1'b0, 4'h0);
        record(5);
        exp_instret++;
        checks++;
        if (r_rf_we !== 8'h10 || r_rf_src !== 8'h10 || r_pc_load !== 8'h10) begin
            errors++;
            $display("FAIL load_wb: got %b/%b/%b expected 00010000 for rf_we/rf_src/pc_load", r_rf_we, r_rf_src, r_pc_load);
        end
        checks++;
        if (r_dmem !== 8'h00) begin errors++; $display("FAIL load_dmem_we: got %b expected 00000000", r_dmem); end
        checks++;
        if (r_cmd[3] !== 4'b0000 || r_src[3] !== 1'b1) begin
            errors++; $display("FAIL load_mem_cmd: got %b/%b expected 0000/1", r_cmd[3], r_src[3]);
        end
        checks++;
        if (instret !== 32'(exp_instret)) begin
            errors++; $display("FAIL load_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_store();
        set_instr(7'b0100011, 3'b011, 1'b0, 4'h0);
        record(4);
        exp_instret++;
        checks++;
        if (r_dmem !== 8'h08 || r_pc_load !== 8'h08) begin
            errors++; $display("FAIL store_mem: got %b/%b expected 00001000/00001000", r_dmem, r_pc_load);
        end
        checks++;
        if (r_rf_we !== 8'h00) begin errors++; $display("FAIL store_rf_we: got %b expected 00000000", r_rf_we); end
        checks++;
        if (instret !== 32'(exp_instret)) begin
            errors++; $display("FAIL store_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_branch();
        logic [2:0] t_f3 [5] = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b101};
        logic [3:0] t_fl [5] = '{4'b0001, 4'b0000, 4'b0000, 4'b0110, 4'b0010};
        logic       t_tk [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            set_instr(7'b1100011, t_f3[i], 1'b0, t_fl[i]);
            record(3);
            exp_instret++;
            checks++;
            if (r_pc_load !== 8'h04 || r_pc_src !== (t_tk[i] ? 8'h04 : 8'h00)) begin
                errors++;
                $display("FAIL branch%0d_pc: got pc_load %b pc_src %b expected 00000100 taken=%b", i, r_pc_load, r_pc_src, t_tk[i]);
            end
            checks++;
            if (r_cmd[2] !== 4'b0011 || r_src[2] !== 1'b0 || r_rf_we !== 8'h00) begin
                errors++;
                $display("FAIL branch%0d_cmd: got %b/%b/%b expected 0011/0/00000000", i, r_cmd[2], r_src[2], r_rf_we);
            end
        end
        checks++;
        if (instret !== 32'(exp_instret)) begin
            errors++; $display("FAIL branch_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_start_ignored();
        set_instr(7'b0110011, 3'b000, 1'b0, 4'h0);
        start = 1'b1;
        record(4);
        start = 1'b0;
        exp_instret++;
        checks++;
        if (r_rf_we !== 8'h08 || r_busy !== 8'h0F) begin
            errors++; $display("FAIL start_ignored_busy: got %b/%b expected 00001000/00001111", r_rf_we, r_busy);
        end
        checks++;
        if (instret !== 32'(exp_instret)) begin
            errors++; $display("FAIL back_to_back_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_illegal();
        set_instr(7'b1111111, 3'b000, 1'b0, 4'h0);
`ifdef UC_ILLEGAL_TRAP_EN
        record(4);
        checks++;
        if (r_busy !== 8'h03 || r_ill !== 8'h0C) begin
            errors++; $display("FAIL illegal_halt: got busy %b illegal %b expected 00000011/00001100", r_busy, r_ill);
        end
        checks++;
        if (r_pc_load !== 8'h00 || r_rf_we !== 8'h00 || r_dmem !== 8'h00) begin
            errors++; $display("FAIL illegal_strobes: got %b/%b/%b expected all 0", r_pc_load, r_rf_we, r_dmem);
        end
        do_start();
        step();
        checks++;
        if (busy !== 1'b0 || illegal !== 1'b1) begin
            errors++; $display("FAIL halt_terminal: got busy %b illegal %b expected 0/1", busy, illegal);
        end
`else
        record(3);
        exp_instret++;
        checks++;
        if (r_pc_load !== 8'h04 || r_pc_src !== 8'h00) begin
            errors++; $display("FAIL illegal_nop_pc: got %b/%b expected 00000100/00000000", r_pc_load, r_pc_src);
        end
        checks++;
        if (r_ill !== 8'h00 || r_rf_we !== 8'h00 || r_dmem !== 8'h00) begin
            errors++; $display("FAIL illegal_nop_flags: got %b/%b/%b expected all 0", r_ill, r_rf_we, r_dmem);
        end
`endif
        checks++;
        if (instret !== 32'(exp_instret)) begin
            errors++; $display("FAIL illegal_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_reset_mid_store();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        exp_instret = 0;
        do_start();
        set_instr(7'b0100011, 3'b010, 1'b0, 4'h0);
        record(3);
        #1;
        checks++;
        if (d_mem_we !== 1'b1) begin errors++; $display("FAIL store_mem_before_reset: got %b expected 1", d_mem_we); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (d_mem_we !== 1'b0 || pc_load !== 1'b0) begin
            errors++; $display("FAIL reset_mid_store_gate: got %b/%b expected 0/0", d_mem_we, pc_load);
        end
        step();
        checks++;
        if (busy !== 1'b0 || instret !== 32'd0) begin
            errors++; $display("FAIL reset_mid_store_idle: got busy %b instret %0d expected 0/0", busy, instret);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_stays_idle: got %b expected 0", busy); end
        do_start();
        set_instr(7'b0110011, 3'b000, 1'b0, 4'h0);
        record(4);
        exp_instret++;
        checks++;
        if (r_rf_we !== 8'h08 || instret !== 32'(exp_instret)) begin
            errors++; $display("FAIL recover_after_reset: got %b/%0d expected 00001000/%0d", r_rf_we, instret, exp_instret);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_load();
        test_store();
        test_branch();
        test_start_ignored();
        test_illegal();
        test_reset_mid_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
